// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: imem request/response, decode hazard inputs, IF/ID outputs
interface fetch_unit_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;
    logic            hazi_redirect;
    logic [XLEN-1:0] fwi_target_addr;
    logic            hazi_stall;
    logic            dst_valid;
    logic [XLEN-1:0] dst_pc;
    logic [ILEN-1:0] dst_instr;

    modport master (
        output imem_req_valid, imem_req_addr, dst_valid, dst_pc, dst_instr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               hazi_redirect, fwi_target_addr, hazi_stall
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dst_valid, dst_pc, dst_instr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               hazi_redirect, fwi_target_addr, hazi_stall
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, single-outstanding imem requests, IQ and IF/ID register
module fetch_unit #(
    parameter int               XLEN     = 32,
    parameter int               ILEN     = 32,
    parameter logic [ILEN-1:0]  NOP      = 32'h0000_0013,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               IQ_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(IQ_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, req_pc;
    logic [XLEN-1:0]   q_pc    [IQ_DEPTH];
    logic [ILEN-1:0]   q_instr [IQ_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              req_fire, push, pop;
    logic              dst_valid_r;
    logic [XLEN-1:0]   dst_pc_r;
    logic [ILEN-1:0]   dst_instr_r;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(IQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Next state: a response always returns to FETCH; a redirect while a word is owed parks in DRAIN
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (req_fire) state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.imem_resp_valid)    state_nxt = S_FETCH;
                else if (bus.hazi_redirect) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (bus.imem_resp_valid) state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Outputs and strobes; outstanding is zero in FETCH, so credit reduces to queue occupancy there
    always_comb begin
        bus.imem_req_valid = !rst && (state == S_FETCH) && !bus.hazi_redirect && (count < DEPTH_C);
        bus.imem_req_addr  = pc;
        req_fire           = bus.imem_req_valid && bus.imem_req_ready;
        push               = (state == S_WAIT) && bus.imem_resp_valid && !bus.hazi_redirect;
        pop                = !bus.hazi_redirect && !bus.hazi_stall && (count != '0);
    end

    // PC and the address of the request in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= '0;
        end else if (bus.hazi_redirect) begin
            pc <= {bus.fwi_target_addr[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            pc     <= pc + XLEN'(4);
            req_pc <= pc;
        end
    end

    // Queue pointers and occupancy; redirect empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.hazi_redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset; occupancy alone says what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= req_pc;
            q_instr[wr_ptr] <= bus.imem_resp_data;
        end
    end

    // IF/ID register: flush on redirect even when stalled, else load head or bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_valid_r <= 1'b0;
            dst_pc_r    <= '0;
            dst_instr_r <= NOP;
        end else if (bus.hazi_redirect) begin
            dst_valid_r <= 1'b0;
            dst_instr_r <= NOP;
        end else if (!bus.hazi_stall) begin
            if (count != '0) begin
                dst_valid_r <= 1'b1;
                dst_pc_r    <= q_pc[rd_ptr];
                dst_instr_r <= q_instr[rd_ptr];
            end else begin
                dst_valid_r <= 1'b0;
                dst_instr_r <= NOP;
            end
        end
    end

    assign bus.dst_valid = dst_valid_r;
    assign bus.dst_pc    = dst_pc_r;
    assign bus.dst_instr = dst_instr_r;

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && count == DEPTH_C));
    a_resp_owed:    assert property (@(posedge clk) disable iff (rst) bus.imem_resp_valid |-> state != S_FETCH);
    a_addr_align:   assert property (@(posedge clk) disable iff (rst) bus.imem_req_addr[1:0] == 2'b00);
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();

    fetch_unit #(.XLEN(32), .ILEN(32), .NOP(NOP), .RESET_PC(32'h100), .IQ_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int fails   = 0;
    logic [31:0] exp_req [$];
    logic [63:0] exp_dst [$];
    int budget    = 0;
    int lat       = 1;
    int acc_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fetch_exp(input logic [31:0] pc, input logic [31:0] word);
        exp_req.push_back(pc);
        exp_dst.push_back({pc, word});
    endtask

    task automatic wait_acc(input int a0);
        int i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (acc_count == a0 && i < 200);
        if (acc_count == a0) begin
            vectors++;
            fails++;
            $display("FAIL acc_timeout: got %0d acceptances expected more than %0d", acc_count, a0);
        end
        #1;
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((exp_req.size() != 0 || exp_dst.size() != 0) && i < 300) begin
            @(posedge clk);
            i++;
        end
        if (exp_req.size() != 0 || exp_dst.size() != 0) begin
            vectors++;
            fails++;
            $display("FAIL idle_timeout: got %0d req / %0d dst pending expected 0", exp_req.size(), exp_dst.size());
            exp_req.delete();
            exp_dst.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Memory responder and request-address monitor
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_cnt             = 0;
                bus.imem_resp_valid = 1'b0;
                bus.imem_req_ready  = 1'b0;
            end else begin
                bus.imem_resp_valid = 1'b0;
                if (mem_cnt > 0) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        bus.imem_resp_valid = 1'b1;
                        bus.imem_resp_data  = {8'h5A, mem_addr[23:0]};
                    end
                end
                bus.imem_req_ready = (budget > 0);
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    if (exp_req.size() == 0) begin
                        vectors++;
                        fails++;
                        $display("FAIL req_unexpected: got %h expected none", bus.imem_req_addr);
                    end else begin
                        check("req_addr", {32'h0, bus.imem_req_addr}, {32'h0, exp_req.pop_front()});
                    end
                    mem_addr = bus.imem_req_addr;
                    mem_cnt  = lat;
                    budget--;
                    acc_count++;
                end
            end
        end
    end

    // IF/ID monitor: loads pop the scoreboard, bubbles must be NOP, stalls must hold
    logic        pend_ld = 1'b0, pend_rd = 1'b0, pend_hold = 1'b0;
    logic [64:0] snap = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_ld   = 1'b0;
                pend_rd   = 1'b0;
                pend_hold = 1'b0;
            end else begin
                if (pend_rd) begin
                    check("flush", {31'h0, bus.dst_valid, bus.dst_instr}, {31'h0, 1'b0, NOP});
                end else if (pend_ld) begin
                    if (bus.dst_valid) begin
                        if (exp_dst.size() == 0) begin
                            vectors++;
                            fails++;
                            $display("FAIL dst_unexpected: got %h/%h expected none", bus.dst_pc, bus.dst_instr);
                        end else begin
                            check("dst", {bus.dst_pc, bus.dst_instr}, exp_dst.pop_front());
                        end
                    end else begin
                        check("bubble_nop", {32'h0, bus.dst_instr}, {32'h0, NOP});
                    end
                end else if (pend_hold) begin
                    check("hold_pc_instr", {bus.dst_pc, bus.dst_instr}, snap[63:0]);
                    check("hold_valid", {63'h0, bus.dst_valid}, {63'h0, snap[64]});
                end
                snap      = {bus.dst_valid, bus.dst_pc, bus.dst_instr};
                pend_rd   = bus.hazi_redirect;
                pend_ld   = !bus.hazi_redirect && !bus.hazi_stall;
                pend_hold = !bus.hazi_redirect && bus.hazi_stall;
            end
        end
    end

    initial begin
        int a0;
        rst                 = 1'b1;
        bus.hazi_redirect   = 1'b0;
        bus.hazi_stall      = 1'b0;
        bus.fwi_target_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        check("rst_dst", {31'h0, bus.dst_valid, bus.dst_pc}, 64'h0);
        check("rst_dst_instr", {32'h0, bus.dst_instr}, {32'h0, NOP});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_req", {31'h0, bus.imem_req_valid, bus.imem_req_addr}, {31'h0, 1'b1, 32'h100});
        check("first_dst", {31'h0, bus.dst_valid, bus.dst_instr}, {31'h0, 1'b0, NOP});

        // Straight-line fetch after reset
        fetch_exp(32'h100, 32'h5A00_0100);
        fetch_exp(32'h104, 32'h5A00_0104);
        fetch_exp(32'h108, 32'h5A00_0108);
        budget = 3;
        wait_idle();

        // Stall five cycles mid-stream
        fetch_exp(32'h10C, 32'h5A00_010C);
        fetch_exp(32'h110, 32'h5A00_0110);
        fetch_exp(32'h114, 32'h5A00_0114);
        fetch_exp(32'h118, 32'h5A00_0118);
        fetch_exp(32'h11C, 32'h5A00_011C);
        fetch_exp(32'h120, 32'h5A00_0120);
        a0 = acc_count;
        budget = 6;
        wait_acc(a0);
        wait_acc(a0 + 1);
        bus.hazi_stall = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_credit", {63'h0, bus.imem_req_valid}, 64'h0);
        @(posedge clk); #1;
        bus.hazi_stall = 1'b0;
        wait_idle();

        // Redirect while in FETCH, target misaligned
        @(posedge clk); #1;
        fetch_exp(32'h200, 32'h5A00_0200);
        budget = 1;
        bus.hazi_redirect   = 1'b1;
        bus.fwi_target_addr = 32'h203;
        @(negedge clk);
        check("redir_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        @(posedge clk); #1;
        bus.hazi_redirect = 1'b0;
        wait_idle();

        // Redirect in WAIT, stale response three cycles after acceptance
        lat = 3;
        exp_req.push_back(32'h204);
        a0 = acc_count;
        budget = 1;
        wait_acc(a0);
        bus.hazi_redirect   = 1'b1;
        bus.fwi_target_addr = 32'h300;
        budget = 1;
        fetch_exp(32'h300, 32'h5A00_0300);
        @(posedge clk); #1;
        bus.hazi_redirect = 1'b0;
        @(negedge clk);
        check("drain_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        wait_idle();
        lat = 1;

        // Redirect in the same cycle as the WAIT response
        exp_req.push_back(32'h304);
        a0 = acc_count;
        budget = 1;
        wait_acc(a0);
        bus.hazi_redirect   = 1'b1;
        bus.fwi_target_addr = 32'h400;
        budget = 1;
        fetch_exp(32'h400, 32'h5A00_0400);
        @(posedge clk); #1;
        bus.hazi_redirect = 1'b0;
        @(negedge clk);
        check("resp_redir_req", {31'h0, bus.imem_req_valid, bus.imem_req_addr}, {31'h0, 1'b1, 32'h400});
        wait_idle();

        // Redirect together with stall turns a held instruction into a bubble
        bus.hazi_stall = 1'b1;
        fetch_exp(32'h404, 32'h5A00_0404);
        exp_req.push_back(32'h408);
        budget = 2;
        repeat (8) @(posedge clk);
        #1;
        bus.hazi_stall = 1'b0;
        @(posedge clk); #1;
        bus.hazi_stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.hazi_redirect   = 1'b1;
        bus.fwi_target_addr = 32'h500;
        fetch_exp(32'h500, 32'h5A00_0500);
        budget = 1;
        @(posedge clk); #1;
        bus.hazi_redirect = 1'b0;
        bus.hazi_stall    = 1'b0;
        wait_idle();

        // PC wrap at the top of the address space
        bus.hazi_redirect   = 1'b1;
        bus.fwi_target_addr = 32'hFFFF_FFFC;
        fetch_exp(32'hFFFF_FFFC, 32'h5AFF_FFFC);
        fetch_exp(32'h0000_0000, 32'h5A00_0000);
        budget = 2;
        @(posedge clk); #1;
        bus.hazi_redirect = 1'b0;
        wait_idle();

        // Reset asserted mid-WAIT while IF/ID holds a valid instruction
        bus.hazi_stall = 1'b1;
        fetch_exp(32'h4, 32'h5A00_0004);
        budget = 1;
        repeat (6) @(posedge clk);
        #1;
        bus.hazi_stall = 1'b0;
        @(posedge clk); #1;
        bus.hazi_stall = 1'b1;
        lat = 3;
        exp_req.push_back(32'h8);
        a0 = acc_count;
        budget = 1;
        wait_acc(a0);
        rst = 1'b1;
        #1;
        check("rst_async", {62'h0, bus.dst_valid, bus.imem_req_valid}, 64'h0);
        check("rst_async_instr", {32'h0, bus.dst_instr}, {32'h0, NOP});
        @(negedge clk);
        check("rst_hold_req", {63'h0, bus.imem_req_valid}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.hazi_stall = 1'b0;
        lat = 1;
        fetch_exp(32'h100, 32'h5A00_0100);
        budget = 1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
